lif_scheduler: RTL and testbench
================================

# lif_scheduler

Time-multiplexed controller that shares one leaky-integrate-and-fire update datapath among `N_NEURONS` neurons. It holds per-neuron input currents and membrane states in local registers. On each `tick` it sweeps all neurons once, one per cycle. Every neuron that fires is emitted as a spike event on a valid/ready port. It sits between the top-level pin wrapper (configuration and monitor) and downstream spike consumers.

## Interface
- `N_NEURONS`, default 4: neuron count; must be a power of two, at least 2.
- `W`, default 8: width of current, state and threshold.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `tick` in 1: start a timestep sweep; single-cycle pulse.
- `clear` in 1: zero all membrane states; honoured only in IDLE.
- `threshold` in W: firing threshold; sampled into a register on the accepted `tick`.
- `cfg_we` in 1: write strobe for the current register.
- `cfg_addr` in log2(N): neuron index for the current write.
- `cfg_data` in W: input current value.
- `mon_addr` in log2(N): neuron index for the monitor.
- `mon_state` out W: membrane state of neuron `mon_addr`, combinational from the state registers.
- `spike_valid` out 1: spike event pending.
- `spike_id` out log2(N): index of the spiking neuron.
- `spike_ready` in 1: consumer accepts the event.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when a sweep completes.
- `overrun` out 1: one-cycle pulse when a `tick` is dropped.

## Operation
- The FSM has states IDLE, RUN and DONE.
- **IDLE, `tick`=1:**
  - Latch `threshold`.
  - Set `idx` to 0 and go to RUN.
- **IDLE, `clear`=1 with `tick`=0:** all states go to 0. If `clear` and `tick` are high together, `tick` wins and `clear` is ignored.
- **RUN:** an update fires when `!(spike_valid && !spike_ready)`. Otherwise the FSM stalls: `idx`, the states and the spike outputs all hold.
- **Update of neuron k:**
  - `s = (v[k] >> 1) + I[k]`, computed at W+1 bits and saturated to 2^W−1.
  - If `s >= thr_q`: spike, `v[k] ← 0`, and on the same edge `spike_valid ← 1`, `spike_id ← k`.
  - Else `v[k] ← s`, and `spike_valid ← 0` if the previous event was accepted this cycle.
- **End of sweep:** after updating `idx = N−1`, go to DONE. Otherwise `idx++`.
- **DONE:**
  - `done` = 1 for this one cycle.
  - If `spike_valid && !spike_ready`, stay in DONE with `done` low after its first cycle; leave when the event is accepted.
  - Return to IDLE.
  - `spike_valid` clears on acceptance.
- **`tick` outside IDLE:** ignored and pulses `overrun` on the next cycle.
- **Config writes:** allowed in any state. If `cfg_addr` equals the neuron updated on the same edge, the update uses the old `I[k]` and the new value is stored.
- `clear` outside IDLE is ignored.
- **Handshake:** an event transfers on an edge where `spike_valid && spike_ready`. While `spike_valid` is high, `spike_id` is stable.

## Timing
- Reset values:
  - All `v[]` = 0, all `I[]` = 0, `thr_q` = 0.
  - FSM = IDLE, `idx` = 0.
  - `spike_valid` = 0, `spike_id` = 0.
  - `busy`, `done`, `overrun` = 0.
- Without stalls, with `tick` sampled at edge t:
  - `busy` is 1 from t+1 through t+N.
  - Neuron k updates at edge t+1+k.
  - DONE is entered at t+N, and `done` is high during the cycle after t+N.
  - Sweep latency is N+1 cycles, tick to `done`.
- A spike from neuron k is visible on `spike_valid`/`spike_id` in the cycle after edge t+1+k.
- Each stall cycle delays all later updates and `done` by one cycle.
- Reset mid-sweep returns to IDLE at once and discards any pending event.
- `mon_state` follows `v[mon_addr]` with zero latency.

## Structure
- **Package `lif_pkg`:**
  - FSM state enum: IDLE, RUN, DONE.
  - Default width `W` = 8.
  - Helper function for the saturating leak-plus-current sum.
- **Sub-module `lif_update`:** combinational datapath.
  - Inputs: `v`, `I`, `thr`.
  - Outputs: `v_next`, `fire`.
  - It is instantiated once and driven by the `idx` mux.
- **Top level `lif_scheduler`:** FSM, register arrays, handshake and monitor mux.

## Test plan
- **Integration:** N=4, `thr`=200, I[0]=120, `spike_ready`=1, three ticks.
  - Neuron 0 steps 120 → 180 → spike.
  - `spike_id`=0 on tick 3, then `v[0]`=0.
- **Saturation:** I[1]=200, `thr`=255, two ticks.
  - Tick 1: `v[1]`=200, no spike.
  - Tick 2: sum 300 saturates to 255, spike `id`=1, `v[1]`=0.
- **Backpressure:** all I=255, `thr`=1, `spike_ready`=0 for 5 cycles after the first valid.
  - `spike_id` holds at 0 and `idx` freezes.
  - After release, ids 0, 1, 2, 3 arrive in order, then `done`.
- **Overrun:** `tick` pulsed 2 cycles after the first tick.
  - One `overrun` pulse.
  - Exactly N updates and one `done`.
- **Clear and config collision:**
  - `clear` during RUN has no effect; `clear` in IDLE zeroes all states, checked via `mon_state`.
  - A `cfg` write to the neuron under update uses the old current this sweep and the new current next sweep.
- **Reset:** async `rst_n` low mid-sweep with `spike_valid`=1.
  - All outputs and states go to 0 immediately.
  - The next tick sweeps from `idx`=0.

Source files
------------

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared FSM encoding, default width and leak/sum helper for the LIF scheduler
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } lif_state_t;

  localparam int LIF_W = 8;

  // (v >> 1) + i clamped to 2^w - 1; the extra top bit keeps the carry for w up to 31
  function automatic logic [31:0] lif_sat_sum(input logic [31:0] v, input logic [31:0] i,
                                              input int w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, v >> 1} + {1'b0, i};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational leak-integrate-fire step for one neuron
module lif_update
  import lif_pkg::*;
#(
  parameter int W = LIF_W
) (
  input  logic [W-1:0] v,
  input  logic [W-1:0] I,
  input  logic [W-1:0] thr,
  output logic [W-1:0] v_next,
  output logic         fire
);

  logic [W-1:0] w_sum;

  assign w_sum  = W'(lif_sat_sum(32'(v), 32'(I), W));
  assign fire   = (w_sum >= thr);
  assign v_next = fire ? '0 : w_sum;

endmodule

// File: rtl/lif_scheduler.sv
// rtl/lif_scheduler.sv - sweeps N neurons through one shared LIF datapath per tick, emitting spikes on valid/ready
module lif_scheduler
  import lif_pkg::*;
#(
  parameter  int N_NEURONS = 4,
  parameter  int W         = LIF_W,
  localparam int AW        = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          clear,
  input  logic [W-1:0]  threshold,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  input  logic [AW-1:0] mon_addr,
  output logic [W-1:0]  mon_state,
  output logic          spike_valid,
  output logic [AW-1:0] spike_id,
  input  logic          spike_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  lif_state_t    r_state;
  lif_state_t    w_state_next;
  logic [AW-1:0] r_idx;
  logic [W-1:0]  r_thr;
  logic [W-1:0]  r_v   [N_NEURONS];
  logic [W-1:0]  r_cur [N_NEURONS];
  logic          r_spike_valid;
  logic [AW-1:0] r_spike_id;
  logic          r_done;
  logic          r_overrun;
  logic          w_update;
  logic          w_last;
  logic          w_fire;
  logic [W-1:0]  w_v_next;
  logic          w_busy;

  // An unaccepted spike blocks the datapath so spike_id never changes under valid
  assign w_update = (r_state == ST_RUN) && !(r_spike_valid && !spike_ready);
  assign w_last   = w_update && (r_idx == AW'(N_NEURONS - 1));

  lif_update #(.W(W)) u_update (
    .v      (r_v[r_idx]),
    .I      (r_cur[r_idx]),
    .thr    (r_thr),
    .v_next (w_v_next),
    .fire   (w_fire)
  );

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: if (tick) w_state_next = ST_RUN;
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: if (!(r_spike_valid && !spike_ready)) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_thr         <= '0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        r_v[k]   <= '0;
        r_cur[k] <= '0;
      end
    end else begin
      r_state   <= w_state_next;
      r_done    <= w_last;
      r_overrun <= tick && (r_state != ST_IDLE);
      if (cfg_we) r_cur[cfg_addr] <= cfg_data;
      if (r_state == ST_IDLE && tick) begin
        r_thr <= threshold;
        r_idx <= '0;
      end else if (r_state == ST_IDLE && clear) begin
        for (int k = 0; k < N_NEURONS; k++) r_v[k] <= '0;
      end
      if (w_update) begin
        r_v[r_idx]    <= w_v_next;
        r_spike_valid <= w_fire;
        if (w_fire) r_spike_id <= r_idx;
        r_idx <= r_idx + AW'(1);
      end else if (r_spike_valid && spike_ready) begin
        r_spike_valid <= 1'b0;
      end
    end
  end

  assign mon_state   = r_v[mon_addr];
  assign spike_valid = r_spike_valid;
  assign spike_id    = r_spike_id;
  assign busy        = w_busy;
  assign done        = r_done;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_lif_scheduler.sv
// tb/tb_lif_scheduler.sv - randomized self-checking bench for lif_scheduler against a timestep-level model
module tb_lif_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          tick;
  logic          clear;
  logic [W-1:0]  threshold;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic [AW-1:0] mon_addr;
  logic [W-1:0]  mon_state;
  logic          spike_valid;
  logic [AW-1:0] spike_id;
  logic          spike_ready;
  logic          busy;
  logic          done;
  logic          overrun;

  int total;
  int bad;
  int v_m [N];
  int i_m [N];
  int got [$];

  lif_scheduler #(.N_NEURONS(N), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .clear       (clear),
    .threshold   (threshold),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .mon_addr    (mon_addr),
    .mon_state   (mon_state),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .spike_ready (spike_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  task automatic check_mon(input string tag);
    for (int k = 0; k < N; k++) begin
      mon_addr = AW'(k);
      #1;
      chk(tag, mon_state, v_m[k]);
    end
  endtask

  task automatic cfg_write(input int k, input int d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = AW'(k); cfg_data = W'(d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    i_m[k] = d;
  endtask

  task automatic clear_idle();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int k = 0; k < N; k++) v_m[k] = 0;
    check_mon("clear_idle_v");
  endtask

  // mode 0: ready always high; 1: random ready; 2: hold ready low 5 cycles after first valid
  task automatic sweep(input int mode, input int thr, input int coll_k, input int coll_d,
                       input int xtick_at, input int clr_at);
    int exp_q [$];
    int vn [N];
    int s, c, first_v, done_at, done_n, ovr_n, hold;
    exp_q = {};
    got   = {};
    for (int k = 0; k < N; k++) begin
      s = v_m[k] / 2 + i_m[k];
      if (s > 255) s = 255;
      if (s >= thr) begin
        exp_q.push_back(k);
        vn[k] = 0;
      end else begin
        vn[k] = s;
      end
    end
    first_v = -1; done_at = -1; done_n = 0; ovr_n = 0; hold = 0;
    @(posedge clk); #1;
    tick = 1'b1; threshold = W'(thr);
    @(posedge clk); #1;
    tick = 1'b0;
    chk("busy_run", busy, 1);
    c = 0;
    while (c < 100) begin
      if (spike_valid && first_v < 0) first_v = c;
      if (overrun) ovr_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && !spike_valid) break;
      tick = 1'b0; cfg_we = 1'b0; clear = 1'b0;
      if (c == xtick_at) tick = 1'b1;
      if (c == clr_at) clear = 1'b1;
      if (c == coll_k) begin
        cfg_we = 1'b1; cfg_addr = AW'(coll_k); cfg_data = W'(coll_d);
      end
      case (mode)
        0: spike_ready = 1'b1;
        1: spike_ready = 1'($urandom_range(0, 1));
        default: begin
          if (spike_valid && hold < 5) begin
            spike_ready = 1'b0;
            hold++;
            chk("bp_id_hold", spike_id, 0);
          end else begin
            spike_ready = 1'b1;
          end
        end
      endcase
      if (spike_valid && spike_ready) got.push_back(int'(spike_id));
      @(posedge clk); #1;
      c++;
    end
    tick = 1'b0; cfg_we = 1'b0; clear = 1'b0; spike_ready = 1'b1;
    chk("done_seen", done_at >= 0, 1);
    @(posedge clk); #1;
    chk("done_cnt", done_n, 1);
    chk("overrun_cnt", ovr_n, (xtick_at >= 0) ? 1 : 0);
    if (mode == 0) chk("latency", done_at, N);
    if (mode == 2) chk("bp_latency", done_at, N + 5);
    if (mode == 0 && exp_q.size() > 0) chk("first_spike_cyc", first_v, exp_q[0] + 1);
    chk("spike_cnt", got.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got.size(); j++) chk("spike_id", got[j], exp_q[j]);
    chk("busy_idle", busy, 0);
    for (int k = 0; k < N; k++) v_m[k] = vn[k];
    if (coll_k >= 0) i_m[coll_k] = coll_d;
    check_mon("sweep_v");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_wr, mode, coll, xt, cl;
    total = 0; bad = 0;
    rst_n = 1'b0; tick = 1'b0; clear = 1'b0; threshold = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; mon_addr = '0; spike_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      v_m[k] = 0; i_m[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", spike_valid, 0);
    chk("rst_id", spike_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    check_mon("rst_v");
    rst_n = 1'b1;

    cfg_write(0, 120);
    sweep(0, 200, -1, 0, -1, -1);
    mon_addr = 0; #1; chk("int_v0_t1", mon_state, 120);
    sweep(0, 200, -1, 0, -1, -1);
    mon_addr = 0; #1; chk("int_v0_t2", mon_state, 180);
    sweep(0, 200, -1, 0, -1, -1);
    chk("int_nspk", got.size(), 1);
    if (got.size() > 0) chk("int_id", got[0], 0);
    mon_addr = 0; #1; chk("int_v0_t3", mon_state, 0);

    cfg_write(0, 0);
    cfg_write(1, 200);
    sweep(0, 255, -1, 0, -1, -1);
    chk("sat_nspk1", got.size(), 0);
    mon_addr = 1; #1; chk("sat_v1_t1", mon_state, 200);
    sweep(0, 255, -1, 0, -1, -1);
    chk("sat_nspk2", got.size(), 1);
    if (got.size() > 0) chk("sat_id", got[0], 1);

    for (int k = 0; k < N; k++) cfg_write(k, 255);
    sweep(2, 1, -1, 0, -1, -1);
    sweep(0, 1, -1, 0, 2, -1);

    for (int k = 0; k < N; k++) cfg_write(k, 100);
    sweep(0, 255, -1, 0, -1, 1);
    clear_idle();

    cfg_write(2, 50);
    sweep(0, 255, 2, 90, -1, -1);
    mon_addr = 2; #1; chk("coll_old_cur", mon_state, 50);
    sweep(0, 255, -1, 0, -1, -1);
    mon_addr = 2; #1; chk("coll_new_cur", mon_state, 115);

    for (int k = 0; k < N; k++) cfg_write(k, 255);
    @(posedge clk); #1;
    spike_ready = 1'b0; tick = 1'b1; threshold = 8'd1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", spike_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", spike_valid, 0);
    chk("mid_rst_id", spike_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    for (int k = 0; k < N; k++) begin
      v_m[k] = 0; i_m[k] = 0;
    end
    check_mon("mid_rst_v");
    @(posedge clk); #1;
    rst_n = 1'b1; spike_ready = 1'b1;
    cfg_write(0, 50);
    sweep(0, 40, -1, 0, -1, -1);

    for (int it = 0; it < 25; it++) begin
      n_wr = $urandom_range(0, 3);
      for (int j = 0; j < n_wr; j++) cfg_write($urandom_range(0, N - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) clear_idle();
      mode = $urandom_range(0, 1);
      coll = (mode == 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, N - 1) : -1;
      xt   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
      cl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
      sweep(mode, $urandom_range(0, 255), coll, $urandom_range(0, 255), xt, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
